instr_fetch_queue: RTL and testbench
====================================

Name: instr_fetch_queue

Overview:
- Upstream stage of the datapath. Fetches instruction words from an instruction memory that has variable latency and uses a req/ack handshake.
- Buffers fetched words in a small prefetch queue. Presents Instr plus its PC to the datapath/decoder using a valid/ready handshake.
- Accepts PC redirects (taken branch or write to PC) from the datapath. On a redirect, flushes stale prefetched words and restarts fetch at the new target.

Parameters:
- DEPTH, 4: queue entries; power of two, minimum 2.
- RESET_PC, 32'h0000_0000: first fetch address after reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset.
- imem_req  output  1  read request to instruction memory; registered.
- imem_addr  output  32  word-aligned fetch address; registered; bits [1:0] always 0.
- imem_ack  input  1  one-cycle pulse; imem_rdata is valid in the same cycle.
- imem_rdata  input  32  instruction word returned by memory.
- redirect  input  1  one-cycle pulse requesting a restart at redirect_pc.
- redirect_pc  input  32  new fetch target; bits [1:0] ignored (treated as 0).
- instr_valid  output  1  queue head is valid.
- instr  output  32  instruction word at the queue head.
- instr_pc  output  32  address of the word at the queue head.
- instr_ready  input  1  consumer accepts the head this cycle.

Behaviour:
- Reset (reset==0 at a clock edge):
  - imem_req=0, imem_addr=RESET_PC, instr_valid=0, instr=0, instr_pc=0.
  - Queue empty, fetch pointer fpc=RESET_PC, state=IDLE.
  - Reset asserted mid-transaction discards everything. Any late imem_ack arriving while reset is low is ignored.
- FSM states: IDLE, WAIT, DRAIN. At most one memory request is outstanding.
- IDLE:
  - If count<DEPTH and no redirect: imem_req<=1, imem_addr<=fpc, go to WAIT.
  - Otherwise stay in IDLE.
  - The first imem_req rises in the first cycle after reset is released.
- WAIT:
  - imem_req and imem_addr are held stable until imem_ack.
  - On imem_ack with no redirect: push {fpc, imem_rdata}, fpc<=fpc+4 (wraps modulo 2^32), imem_req<=0, go to IDLE.
  - There is always one idle cycle between requests.
- DRAIN:
  - Entered when a redirect arrives in WAIT without imem_ack. An issued request is never retracted.
  - imem_req stays high. On imem_ack the data is discarded, imem_req<=0, go to IDLE.
  - A further redirect while in DRAIN overwrites fpc and the FSM stays in DRAIN.
- Redirect, in any state:
  - Flush the queue: count<=0, instr_valid<=0 next cycle.
  - Load fpc<=redirect_pc & ~3.
  - Redirect has priority over a same-cycle pop and push.
  - Redirect coinciding with imem_ack in WAIT: the returned word is dropped and the FSM goes to IDLE (no DRAIN).
- Queue:
  - Circular buffer with wr_ptr, rd_ptr and count (0..DEPTH).
  - Output registers reflect the head. A word pushed at edge N is visible (instr_valid=1) after edge N+1 at the earliest.
  - Minimum ack-to-valid latency is 1 cycle when the queue was empty.
  - A pop occurs on instr_valid && instr_ready.
  - A push and a pop in the same cycle leave count unchanged.
  - Overflow is impossible: a request is only issued when count<DEPTH, only one is outstanding, and pops only decrease count.
  - When the queue is full, IDLE holds off requests. Fetch resumes in the cycle after the first pop.
  - When the queue is empty, instr_valid=0 and instr/instr_pc hold their last values.
  - instr_ready while instr_valid=0 has no effect.
- Throughput: one word per 2 cycles at zero memory wait states. The consumer may stall indefinitely; instr and instr_pc stay stable while instr_valid=1 and instr_ready=0.

Decomposition:
- Shared package fetch_pkg:
  - typedef fetch_state_e {IDLE, WAIT, DRAIN}.
  - typedef struct fetch_entry_t {logic [31:0] pc; logic [31:0] word;}.
  - Constants RESET_PC_DEFAULT and FETCH_DEPTH_DEFAULT.
- One sub-module, fetch_fifo: parameterised DEPTH circular buffer of fetch_entry_t with push, pop, flush, count, and a registered head output.
- The FSM and fpc logic live in instr_fetch_queue.

Test Plan:
- Reset release, zero-wait memory (ack 1 cycle after req), instr_ready=1:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - instr_pc matches each address, and instr equals the rdata returned for it.
- instr_ready=0 with DEPTH=4:
  - Exactly 4 requests (0x0–0xC) are issued and then imem_req stays 0.
  - After a single pop, the next request goes to 0x10 one cycle later.
- Redirect to 0x103 while the queue holds 3 words and no request is outstanding:
  - instr_valid=0 next cycle.
  - The next imem_addr is 0x100 and the first valid instr_pc is 0x100.
- Redirect to 0x200 in WAIT, with ack arriving 3 cycles later (rdata=0xDEADBEEF):
  - imem_req stays high until the ack.
  - 0xDEADBEEF is never presented.
  - The next request is to 0x200.
- Redirect in the same cycle as imem_ack, and separately a redirect during DRAIN to 0x300 then 0x400:
  - The acked word is dropped.
  - Fetch resumes at the latest target (0x400).
- reset=0 asserted in WAIT, with a stray ack during reset:
  - All outputs return to their reset values and the queue is empty.
  - The first request after release is to RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch queue.
//   fetch_state_e : fetch FSM states
//   fetch_entry_t : one prefetched word together with its address
//   align_word    : clears bits [1:0] of an address
package fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT    = 32'h0000_0000;
  localparam int unsigned FETCH_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } fetch_entry_t;

  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch buffer with a registered head.
//   clk, reset        : clock, synchronous active-low reset
//   i_push, i_pc,
//   i_word            : write one entry at the tail
//   i_ready           : consumer accepts the head (pop when o_valid)
//   i_flush           : discard all entries; wins over push and pop
//   o_count           : number of stored entries, including the head
//   o_valid, o_pc,
//   o_word            : registered head; pc/word hold when empty
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = FETCH_DEPTH_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [31:0]              i_pc,
  input  logic [31:0]              i_word,
  input  logic                     i_ready,
  input  logic                     i_flush,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_valid,
  output logic [31:0]              o_pc,
  output logic [31:0]              o_word
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_valid;
  fetch_entry_t     r_head;

  logic             w_pop;
  logic [PTR_W-1:0] w_rd_next;
  logic [CNT_W-1:0] w_cnt_after_pop;
  fetch_entry_t     w_entry;

  assign w_pop           = r_valid & i_ready & ~i_flush;
  assign w_rd_next       = w_pop ? r_rd_ptr + PTR_W'(1) : r_rd_ptr;
  assign w_cnt_after_pop = r_count - CNT_W'(w_pop);
  assign w_entry.pc      = i_pc;
  assign w_entry.word    = i_word;

  // Storage array; not reset, only entries covered by r_count are ever read.
  always_ff @(posedge clk) begin
    if (reset && !i_flush && i_push) begin
      r_mem[r_wr_ptr] <= w_entry;
    end
  end

  // Pointers, occupancy and head register. The head is loaded only from
  // entries that already existed before this edge, so a word pushed at one
  // edge becomes visible one edge later.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_head   <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_cnt_after_pop + CNT_W'(i_push);
      r_valid  <= (w_cnt_after_pop != '0);
      if (w_cnt_after_pop != '0) begin
        r_head <= r_mem[w_rd_next];
      end
    end
  end

  assign o_count = r_count;
  assign o_valid = r_valid;
  assign o_pc    = r_head.pc;
  assign o_word  = r_head.word;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front end: issues single-outstanding req/ack reads to
// instruction memory, buffers the returned words and presents them with
// their PC over valid/ready. A redirect flushes the buffer and restarts
// fetch at the new target; a request already issued is drained, not retracted.
//   clk, reset                : clock, synchronous active-low reset
//   imem_req, imem_addr       : registered memory request / word address
//   imem_ack, imem_rdata      : memory response pulse and data
//   redirect, redirect_pc     : restart fetch at redirect_pc (bits [1:0] ignored)
//   instr_valid, instr,
//   instr_pc, instr_ready     : decoder-side handshake
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = FETCH_DEPTH_DEFAULT,
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned CNT_W      = $clog2(DEPTH) + 1;
  localparam logic [31:0] RESET_PC_A = RESET_PC & 32'hFFFF_FFFC;

  fetch_state_e     r_state;
  logic [31:0]      r_fpc;
  logic             r_req;
  logic [31:0]      r_addr;

  logic [CNT_W-1:0] w_count;
  logic [31:0]      w_target;
  logic             w_push;

  assign w_target = align_word(redirect_pc);
  // A word returned together with a redirect is stale and dropped.
  assign w_push   = (r_state == WAIT) & imem_ack & ~redirect;

  // Fetch FSM and fetch pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_fpc   <= RESET_PC_A;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC_A;
    end else begin
      case (r_state)
        IDLE: begin
          if (redirect) begin
            r_fpc <= w_target;
          end else if (w_count < CNT_W'(DEPTH)) begin
            r_req   <= 1'b1;
            r_addr  <= r_fpc;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_ack) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
            r_fpc   <= redirect ? w_target : r_fpc + 32'd4;
          end else if (redirect) begin
            r_fpc   <= w_target;
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (redirect) begin
            r_fpc <= w_target;
          end
          if (imem_ack) begin
            r_req   <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pc    (r_fpc),
    .i_word  (imem_rdata),
    .i_ready (instr_ready),
    .i_flush (redirect),
    .o_count (w_count),
    .o_valid (instr_valid),
    .o_pc    (instr_pc),
    .o_word  (instr)
  );

  assign imem_req  = r_req;
  assign imem_addr = r_addr;

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  always #5 clk = ~clk;

  instr_fetch_queue #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_ready (instr_ready)
  );

  int checks   = 0;
  int failures = 0;

  fetch_entry_t exp_q[$];
  logic [31:0]  req_log[$];

  // memory / consumer model state
  bit          mem_auto;
  int          mem_lat;
  int          mem_wait;
  bit          busy;
  logic [31:0] out_addr;
  bit          drop_pending;
  bit          man_ack;
  logic [31:0] man_rdata;
  bit          redir_cfg;
  logic [31:0] redir_pc_cfg;
  bit          rdy_cfg;
  int          pops;
  logic [31:0] first_pop_pc;
  logic [31:0] last_pop_pc;
  bit          saw_beef;

  // values sampled at the start of the most recent cycle()
  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_pc;

  function automatic logic [31:0] gen_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic clear_model();
    exp_q.delete();
    req_log.delete();
    busy         = 1'b0;
    drop_pending = 1'b0;
    pops         = 0;
    saw_beef     = 1'b0;
    redir_cfg    = 1'b0;
    man_ack      = 1'b0;
  endtask

  // One clock cycle: sample outputs at the negedge, score pops, model the
  // memory, then drive this cycle's inputs ahead of the next rising edge.
  task automatic cycle();
    fetch_entry_t e;
    logic         ack;
    logic [31:0]  rd;
    @(negedge clk);
    s_req   = imem_req;
    s_valid = instr_valid;
    s_addr  = imem_addr;
    s_pc    = instr_pc;
    if (instr_valid && instr === 32'hDEAD_BEEF) saw_beef = 1'b1;

    if (!busy && imem_req) begin
      busy     = 1'b1;
      out_addr = imem_addr;
      mem_wait = mem_lat;
      req_log.push_back(imem_addr);
    end else if (busy) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== out_addr) begin
        failures++;
        $display("FAIL req_hold actual req=%b addr=%h required req=1 addr=%h",
                 imem_req, imem_addr, out_addr);
      end
    end

    instr_ready = rdy_cfg;
    if (instr_valid && rdy_cfg && !redir_cfg) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pop actual pc=%h instr=%h required none", instr_pc, instr);
      end else begin
        e = exp_q.pop_front();
        if (instr_pc !== e.pc || instr !== e.word) begin
          failures++;
          $display("FAIL pop_data actual pc=%h instr=%h required pc=%h instr=%h",
                   instr_pc, instr, e.pc, e.word);
        end
      end
      if (pops == 0) first_pop_pc = instr_pc;
      last_pop_pc = instr_pc;
      pops++;
    end

    ack = 1'b0;
    rd  = 32'h0;
    if (mem_auto) begin
      if (busy) begin
        if (mem_wait == 0) begin
          ack = 1'b1;
          rd  = gen_word(out_addr);
        end else begin
          mem_wait--;
        end
      end
    end else begin
      ack = man_ack;
      rd  = man_rdata;
    end
    imem_ack    = ack;
    imem_rdata  = rd;
    redirect    = redir_cfg;
    redirect_pc = redir_pc_cfg;

    if (ack && busy) begin
      busy = 1'b0;
      if (!redir_cfg && !drop_pending) begin
        e.pc   = out_addr;
        e.word = rd;
        exp_q.push_back(e);
      end
      drop_pending = 1'b0;
    end else if (redir_cfg && busy) begin
      drop_pending = 1'b1;
    end
    if (redir_cfg) exp_q.delete();
    redir_cfg = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset       = 1'b0;
    imem_ack    = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b0;
    rdy_cfg     = 1'b0;
    repeat (2) @(negedge clk);
    clear_model();
    reset = 1'b1;
  endtask

  task automatic wait_req_count(input int n, input string name);
    int k = 0;
    while (req_log.size() < n && k < 12) begin
      cycle();
      k++;
    end
    checks++;
    if (req_log.size() < n) begin
      failures++;
      $display("FAIL %s_timeout actual reqs=%0d required %0d", name, req_log.size(), n);
    end
  endtask

  task automatic test_reset();
    imem_ack = 1'b0; imem_rdata = 32'h0; redirect = 1'b0; redirect_pc = 32'h0;
    instr_ready = 1'b0; reset = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
        instr !== 32'h0 || instr_pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_values actual req=%b addr=%h v=%b instr=%h pc=%h required all 0",
               imem_req, imem_addr, instr_valid, instr, instr_pc);
    end
    reset = 1'b1;
    mem_auto = 1'b0;
    cycle();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0) begin
      failures++;
      $display("FAIL first_req actual req=%b addr=%h required req=1 addr=00000000", s_req, s_addr);
    end
  endtask

  task automatic test_sequential();
    do_reset();
    mem_auto = 1'b1; mem_lat = 1; rdy_cfg = 1'b1;
    repeat (14) cycle();
    wait_req_count(3, "seq");
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (req_log.size() <= i || req_log[i] !== 32'(4 * i)) begin
        failures++;
        $display("FAIL seq_addr%0d actual %h required %h", i,
                 (req_log.size() > i) ? req_log[i] : 32'hX, 32'(4 * i));
      end
    end
    checks++;
    if (pops < 3) begin
      failures++;
      $display("FAIL seq_pops actual %0d required >=3", pops);
    end
  endtask

  task automatic test_full();
    do_reset();
    mem_auto = 1'b1; mem_lat = 1; rdy_cfg = 1'b0;
    repeat (24) cycle();
    checks++;
    if (req_log.size() != 4) begin
      failures++;
      $display("FAIL full_req_count actual %0d required 4", req_log.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (req_log.size() <= i || req_log[i] !== 32'(4 * i)) begin
        failures++;
        $display("FAIL full_addr%0d actual %h required %h", i,
                 (req_log.size() > i) ? req_log[i] : 32'hX, 32'(4 * i));
      end
    end
    checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b1 || s_pc !== 32'h0) begin
      failures++;
      $display("FAIL full_hold actual req=%b v=%b pc=%h required req=0 v=1 pc=00000000",
               s_req, s_valid, s_pc);
    end
    rdy_cfg = 1'b1;
    cycle();
    rdy_cfg = 1'b0;
    cycle();
    checks++;
    if (req_log.size() != 4) begin
      failures++;
      $display("FAIL full_resume_early actual reqs=%0d required 4", req_log.size());
    end
    cycle();
    checks++;
    if (req_log.size() != 5 || req_log[req_log.size()-1] !== 32'h10) begin
      failures++;
      $display("FAIL full_resume actual reqs=%0d last=%h required 5 last=00000010",
               req_log.size(), req_log[req_log.size()-1]);
    end
    rdy_cfg = 1'b1;
    repeat (16) cycle();
  endtask

  task automatic test_redirect_idle();
    int k = 0;
    int n;
    do_reset();
    mem_auto = 1'b1; mem_lat = 1; rdy_cfg = 1'b0;
    while (exp_q.size() < 3 && k < 20) begin cycle(); k++; end
    redir_cfg = 1'b1; redir_pc_cfg = 32'h0000_0103;
    cycle();
    checks++;
    if (s_req !== 1'b0 || s_valid !== 1'b1) begin
      failures++;
      $display("FAIL ridle_pre actual req=%b v=%b required req=0 v=1", s_req, s_valid);
    end
    n = req_log.size();
    cycle();
    checks++;
    if (s_valid !== 1'b0) begin
      failures++;
      $display("FAIL ridle_flush actual v=%b required 0", s_valid);
    end
    wait_req_count(n + 1, "ridle");
    checks++;
    if (req_log[req_log.size()-1] !== 32'h100) begin
      failures++;
      $display("FAIL ridle_addr actual %h required 00000100", req_log[req_log.size()-1]);
    end
    rdy_cfg = 1'b1;
    n = pops;
    k = 0;
    while (pops == n && k < 10) begin cycle(); k++; end
    checks++;
    if (pops == n || last_pop_pc !== 32'h100) begin
      failures++;
      $display("FAIL ridle_pc actual pops=%0d pc=%h required pc=00000100", pops - n, last_pop_pc);
    end
    repeat (4) cycle();
  endtask

  task automatic test_redirect_wait();
    do_reset();
    mem_auto = 1'b0; man_ack = 1'b0; rdy_cfg = 1'b1;
    wait_req_count(1, "rwait_first");
    redir_cfg = 1'b1; redir_pc_cfg = 32'h0000_0200;
    cycle();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin man_ack = 1'b1; man_rdata = 32'hDEAD_BEEF; end
      cycle();
      checks++;
      if (s_req !== 1'b1) begin
        failures++;
        $display("FAIL rwait_hold%0d actual req=%b required 1", i, s_req);
      end
    end
    man_ack = 1'b0;
    mem_auto = 1'b1; mem_lat = 1;
    wait_req_count(2, "rwait");
    checks++;
    if (req_log[req_log.size()-1] !== 32'h200) begin
      failures++;
      $display("FAIL rwait_addr actual %h required 00000200", req_log[req_log.size()-1]);
    end
    repeat (10) cycle();
    checks++;
    if (saw_beef || pops < 1 || first_pop_pc !== 32'h200) begin
      failures++;
      $display("FAIL rwait_drop actual beef=%b pops=%0d pc=%h required beef=0 pc=00000200",
               saw_beef, pops, first_pop_pc);
    end
  endtask

  task automatic test_redirect_ack_drain();
    int k = 0;
    do_reset();
    mem_auto = 1'b0; man_ack = 1'b0; rdy_cfg = 1'b1;
    wait_req_count(1, "rack_first");
    man_ack = 1'b1; man_rdata = 32'h1111_1111;
    redir_cfg = 1'b1; redir_pc_cfg = 32'h0000_0180;
    cycle();
    man_ack = 1'b0;
    wait_req_count(2, "rack");
    checks++;
    if (req_log[req_log.size()-1] !== 32'h180) begin
      failures++;
      $display("FAIL rack_addr actual %h required 00000180", req_log[req_log.size()-1]);
    end
    redir_cfg = 1'b1; redir_pc_cfg = 32'h0000_0300;
    cycle();
    redir_cfg = 1'b1; redir_pc_cfg = 32'h0000_0400;
    cycle();
    man_ack = 1'b1; man_rdata = 32'h2222_2222;
    cycle();
    man_ack = 1'b0;
    mem_auto = 1'b1; mem_lat = 1;
    wait_req_count(3, "rdrain");
    checks++;
    if (req_log[req_log.size()-1] !== 32'h400) begin
      failures++;
      $display("FAIL rdrain_addr actual %h required 00000400", req_log[req_log.size()-1]);
    end
    while (pops == 0 && k < 10) begin cycle(); k++; end
    checks++;
    if (pops == 0 || first_pop_pc !== 32'h400) begin
      failures++;
      $display("FAIL rdrain_pc actual pops=%0d pc=%h required pc=00000400", pops, first_pop_pc);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    do_reset();
    mem_auto = 1'b1; mem_lat = 1; rdy_cfg = 1'b0;
    while (exp_q.size() < 2 && k < 20) begin cycle(); k++; end
    mem_auto = 1'b0; man_ack = 1'b0;
    wait_req_count(3, "rmid_wait");
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    redirect = 1'b0; instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (imem_req !== 1'b0 || imem_addr !== 32'h0 || instr_valid !== 1'b0 ||
        instr !== 32'h0 || instr_pc !== 32'h0) begin
      failures++;
      $display("FAIL rmid_values actual req=%b addr=%h v=%b instr=%h pc=%h required all 0",
               imem_req, imem_addr, instr_valid, instr, instr_pc);
    end
    imem_ack = 1'b0;
    clear_model();
    reset = 1'b1;
    mem_auto = 1'b1; mem_lat = 1; rdy_cfg = 1'b1;
    cycle();
    checks++;
    if (s_req !== 1'b1 || s_addr !== 32'h0 || s_valid !== 1'b0) begin
      failures++;
      $display("FAIL rmid_first actual req=%b addr=%h v=%b required req=1 addr=00000000 v=0",
               s_req, s_addr, s_valid);
    end
    repeat (8) cycle();
    checks++;
    if (pops == 0 || first_pop_pc !== 32'h0) begin
      failures++;
      $display("FAIL rmid_pop actual pops=%0d pc=%h required pc=00000000", pops, first_pop_pc);
    end
  endtask

  initial begin
    mem_auto = 1'b0; mem_lat = 1; mem_wait = 0; man_rdata = 32'h0;
    redir_pc_cfg = 32'h0; rdy_cfg = 1'b0; first_pop_pc = 32'h0; last_pop_pc = 32'h0;
    test_reset();
    test_sequential();
    test_full();
    test_redirect_idle();
    test_redirect_wait();
    test_redirect_ack_drain();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
